sdram_arbiter: RTL

Round-robin arbiter that shares the single user port of `sdram_controller` between `N_REQ` requesters, e.g. CPU data port and DMA. Holds one granted request in an issue register and presents it to the controller only while `ctl_busy` is low. Records the owner of every issued read in an in-order ID FIFO so each `ctl_out_valid` pulse is routed back to the correct requester. Sits between the requester interconnect and `sdram_controller`, in the same clock domain.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_arbiter_if.sv | 43 ++++
 rtl/sdram_rsp_fifo.sv | 60 ++++++
 rtl/sdram_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM types and constants.
// Used by the arbiter and by controller wrappers.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 23;
    localparam int SDRAM_DATA_W = 32;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_ISSUE = 1'b1
    } arb_state_t;

    // Width of a requester ID; at least one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and controller-facing bus of the SDRAM arbiter.
// master = requesters + controller side, slave = arbiter.
interface sdram_arbiter_if
    import sdram_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_rw;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    ctl_in_valid;
    logic                    ctl_rw;
    logic [ADDR_W-1:0]       ctl_addr;
    logic [DATA_W-1:0]       ctl_wdata;
    logic                    ctl_busy;
    logic                    ctl_out_valid;
    logic [DATA_W-1:0]       ctl_rdata;
    logic                    err_spurious;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        output ctl_busy, ctl_out_valid, ctl_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ctl_in_valid, ctl_rw, ctl_addr, ctl_wdata,
        input  err_spurious
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        input  ctl_busy, ctl_out_valid, ctl_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output ctl_in_valid, ctl_rw, ctl_addr, ctl_wdata,
        output err_spurious
    );

endinterface

// File: rtl/sdram_rsp_fifo.sv
// In-order FIFO of read-owner IDs.
// Head is the owner of the oldest outstanding read.
module sdram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter for the sdram_controller user port.
// Routes read data back through an in-order owner FIFO.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_W     = SDRAM_ADDR_W,
    parameter int DATA_W     = SDRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    sdram_arbiter_if.slave bus
);

    localparam int ID_W = id_w(N_REQ);

    arb_state_t        state;
    arb_state_t        state_d;
    logic              is_rw;
    logic [ADDR_W-1:0] is_addr;
    logic [DATA_W-1:0] is_wdata;
    logic [ID_W-1:0]   is_id;
    logic [ID_W-1:0]   rr_ptr;

    logic              found;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   cand;
    logic              issue;
    logic              grant;

    logic              fifo_full;
    logic              fifo_empty;
    logic [ID_W-1:0]   fifo_head;
    logic              fifo_push;
    logic              fifo_pop;

    logic [N_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              err_q;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Issue/grant decisions and next state.
    always_comb begin
        state_d = state;
        issue   = rst && (state == S_ISSUE) && !bus.ctl_busy
                  && (is_rw || !fifo_full);
        grant   = rst && found && ((state == S_EMPTY) || issue);
        unique case (state)
            S_EMPTY: begin
                if (grant) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue && !grant) begin
                    state_d = S_EMPTY;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_d;
        end
    end

    // Issue register and round-robin pointer, loaded on grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_rw    <= 1'b0;
            is_addr  <= '0;
            is_wdata <= '0;
            is_id    <= '0;
            rr_ptr   <= '0;
        end else if (grant) begin
            is_rw    <= bus.req_rw[win];
            is_addr  <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
            is_wdata <= bus.req_wdata[int'(win)*DATA_W +: DATA_W];
            is_id    <= win;
            rr_ptr   <= ID_W'((int'(win) + 1) % N_REQ);
        end
    end

    assign fifo_push = issue && !is_rw;
    assign fifo_pop  = rst && bus.ctl_out_valid && !fifo_empty;

    sdram_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .push_id (is_id),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Response routing one cycle after the pop; sticky spurious flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= fifo_pop ? (N_REQ'(1) << fifo_head) : '0;
            if (fifo_pop) begin
                rsp_rdata_q <= bus.ctl_rdata;
            end
            if (bus.ctl_out_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready    = grant ? (N_REQ'(1) << win) : '0;
    assign bus.ctl_in_valid = issue;
    assign bus.ctl_rw       = is_rw;
    assign bus.ctl_addr     = is_addr;
    assign bus.ctl_wdata    = is_wdata;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.err_spurious = err_q;

endmodule
